// File: rtl/overlay_controller_if.sv
// ----------------------------------------------------------------------------
// overlay_controller_if
//   Bundles the two synchronous ROM ports used by overlay_controller:
//   the icon sprite ROM and the READY banner ROM.
//
//   The address widths must match the overlay_controller instance:
//     ICON_ADDR_W  = $clog2(NUM_ICONS) + 1 + $clog2(ICON_H*ICON_W)
//     READY_ADDR_W = $clog2(READY_H*READY_W)
//
// Signals
//   icon_rom_addr   {slot, eaten, row, col} driven by the controller
//   icon_rom_data   2-bit colour index, valid 1 cycle after the address
//   ready_rom_addr  {row, col} driven by the controller
//   ready_rom_data  1-bit banner mask, valid 1 cycle after the address
//
// Modports
//   master  overlay_controller side (drives the addresses)
//   slave   ROM side (returns the data)
// ----------------------------------------------------------------------------
interface overlay_controller_if #(
    parameter int ICON_ADDR_W  = 10,
    parameter int READY_ADDR_W = 9
);
    logic [ICON_ADDR_W-1:0]  icon_rom_addr;
    logic [1:0]              icon_rom_data;
    logic [READY_ADDR_W-1:0] ready_rom_addr;
    logic                    ready_rom_data;

    modport master (
        output icon_rom_addr,
        output ready_rom_addr,
        input  icon_rom_data,
        input  ready_rom_data
    );

    modport slave (
        input  icon_rom_addr,
        input  ready_rom_addr,
        output icon_rom_data,
        output ready_rom_data
    );
endinterface

// File: rtl/overlay_controller.sv
// ----------------------------------------------------------------------------
// overlay_controller
//   HUD overlay for the bonus icon row and the READY banner, plus the
//   level-start / death stall timer that freezes gameplay.
//
//   Pipeline: stage 0 decodes the VGA counters into box hits and ROM
//   addresses, stage 1 registers the addresses and hit flags, stage 2
//   registers the final colour from the ROM data. Counter-to-pixel latency
//   is 2 clocks.
//
//   Optional feature macro: OVERLAY_BLINK_EN
//     defined   -> READY banner blinks at 1 Hz while stalled (shown in the
//                  1st, 3rd, ... second of the stall)
//     undefined -> READY banner is shown for the whole stall
//
// Ports
//   clk            pixel clock
//   reset          asynchronous, active-low reset
//   h_counter      VGA horizontal position (11 bits)
//   v_counter      VGA vertical position (10 bits)
//   one_hz_enable  1-cycle strobe once per second
//   pause          freezes the stall timer and the blink phase
//   pacman_dead    level restart request, sampled every cycle
//   bonus_eaten    per-slot eaten flag, bit i -> slot i
//   rom            overlay_controller_if.master: icon and READY ROM ports
//   overlay_pixel  RGB332 colour
//   overlay_en     overlay pixel is opaque this cycle
//   stall          gameplay frozen
//   countdown      seconds remaining while stalled, 0 when running
// ----------------------------------------------------------------------------
module overlay_controller #(
    parameter int NUM_ICONS = 2,
    parameter int ICON_W    = 16,
    parameter int ICON_H    = 16,
    parameter int ICON_X0   = 600,
    parameter int ICON_STEP = 24,
    parameter int ICON_Y    = 440,
    parameter int READY_X   = 272,
    parameter int READY_Y   = 260,
    parameter int READY_W   = 64,
    parameter int READY_H   = 8,
    parameter int COUNT_SEC = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           h_counter,
    input  logic [9:0]            v_counter,
    input  logic                  one_hz_enable,
    input  logic                  pause,
    input  logic                  pacman_dead,
    input  logic [NUM_ICONS-1:0]  bonus_eaten,
    overlay_controller_if.master  rom,
    output logic [7:0]            overlay_pixel,
    output logic                  overlay_en,
    output logic                  stall,
    output logic [3:0]            countdown
);

    localparam int ICOL_W       = $clog2(ICON_W);
    localparam int IROW_W       = $clog2(ICON_H);
    localparam int SLOT_W       = $clog2(NUM_ICONS);
    localparam int SLOT_IW      = (SLOT_W > 0) ? SLOT_W : 1;
    localparam int ICON_ADDR_W  = SLOT_W + 1 + IROW_W + ICOL_W;
    localparam int RCOL_W       = $clog2(READY_W);
    localparam int RROW_W       = $clog2(READY_H);
    localparam int READY_ADDR_W = RROW_W + RCOL_W;
    localparam logic [3:0] LAST_COUNT = 4'(COUNT_SEC - 1);

    typedef enum logic {
        ST_STALL = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Stall timer FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       advance;
    logic       show_ready;

    assign advance = one_hz_enable & ~pause;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STALL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_STALL: begin
                // A death request restarts the countdown and overrides expiry.
                if (pacman_dead) begin
                    count_d = '0;
                end else if (advance) begin
                    if (count_q == LAST_COUNT) begin
                        state_d = ST_RUN;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
            end
            ST_RUN: begin
                if (pacman_dead) begin
                    state_d = ST_STALL;
                    count_d = '0;
                end
            end
            default: begin
                state_d = ST_STALL;
                count_d = '0;
            end
        endcase
    end

    assign stall     = (state_q == ST_STALL);
    assign countdown = stall ? (4'(COUNT_SEC) - count_q) : 4'd0;

`ifdef OVERLAY_BLINK_EN
    // Blink phase: 1 at the start of every stall (including a restart while
    // already stalled), toggles on each unpaused second.
    logic phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (pacman_dead) begin
            phase_d = 1'b1;
        end else if (stall && advance) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= 1'b1;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign show_ready = stall & phase_q;
`else
    assign show_ready = stall;
`endif

    // ------------------------------------------------------------------
    // Stage 0: window decode on the raw counters
    // ------------------------------------------------------------------
    logic                    icon_v_in;
    logic [IROW_W-1:0]       icon_row;
    logic                    icon_hit;
    logic [SLOT_IW-1:0]      hit_slot;
    logic                    hit_eaten;
    logic [ICOL_W-1:0]       hit_col;
    logic [ICON_ADDR_W-1:0]  icon_addr_d;
    logic                    ready_in_box;
    logic                    ready_hit;
    logic [READY_ADDR_W-1:0] ready_addr_d;

    assign icon_v_in = (v_counter >= 10'(ICON_Y)) && (v_counter < 10'(ICON_Y + ICON_H));
    assign icon_row  = IROW_W'(v_counter - 10'(ICON_Y));

    // Scan from the highest slot down so the lowest hit index is written last.
    always_comb begin
        icon_hit  = 1'b0;
        hit_slot  = '0;
        hit_eaten = 1'b0;
        hit_col   = '0;
        for (int i = NUM_ICONS - 1; i >= 0; i--) begin
            if ((h_counter >= 11'(ICON_X0 + i * ICON_STEP)) &&
                (h_counter <  11'(ICON_X0 + i * ICON_STEP + ICON_W))) begin
                icon_hit  = 1'b1;
                hit_slot  = SLOT_IW'(i);
                hit_eaten = bonus_eaten[i];
                hit_col   = ICOL_W'(h_counter - 11'(ICON_X0 + i * ICON_STEP));
            end
        end
        // Icons are hidden while gameplay is frozen.
        icon_hit = icon_hit & icon_v_in & ~stall;
    end

    // Shifts instead of a concatenation so a single-slot build (zero-width
    // slot field) still elaborates.
    assign icon_addr_d = icon_hit
        ? ((ICON_ADDR_W'(hit_slot)  << (1 + IROW_W + ICOL_W)) |
           (ICON_ADDR_W'(hit_eaten) << (IROW_W + ICOL_W))     |
           (ICON_ADDR_W'(icon_row)  << ICOL_W)                |
            ICON_ADDR_W'(hit_col))
        : '0;

    assign ready_in_box = (h_counter >= 11'(READY_X)) && (h_counter < 11'(READY_X + READY_W)) &&
                          (v_counter >= 10'(READY_Y)) && (v_counter < 10'(READY_Y + READY_H));
    assign ready_hit    = ready_in_box & show_ready;
    assign ready_addr_d = ready_hit
        ? {RROW_W'(v_counter - 10'(READY_Y)), RCOL_W'(h_counter - 11'(READY_X))}
        : '0;

    // ------------------------------------------------------------------
    // Stage 1: ROM addresses and hit flags (slot and eaten travel inside
    // the icon address)
    // ------------------------------------------------------------------
    logic s1_icon_hit, s1_ready_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom.icon_rom_addr  <= '0;
            rom.ready_rom_addr <= '0;
            s1_icon_hit        <= 1'b0;
            s1_ready_hit       <= 1'b0;
        end else begin
            rom.icon_rom_addr  <= icon_addr_d;
            rom.ready_rom_addr <= ready_addr_d;
            s1_icon_hit        <= icon_hit;
            s1_ready_hit       <= ready_hit;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: palette lookup and output register
    // ------------------------------------------------------------------
    logic [7:0] pixel_d;
    logic       en_d;

    always_comb begin
        pixel_d = 8'h00;
        en_d    = 1'b0;
        if (s1_ready_hit) begin
            // The banner is opaque across the whole box, black where the mask is 0.
            en_d    = 1'b1;
            pixel_d = rom.ready_rom_data ? 8'hFC : 8'h00;
        end else if (s1_icon_hit) begin
            case (rom.icon_rom_data)
                2'b01:   begin en_d = 1'b1; pixel_d = 8'hE0; end
                2'b10:   begin en_d = 1'b1; pixel_d = 8'h20; end
                2'b11:   begin en_d = 1'b1; pixel_d = 8'hFF; end
                default: begin en_d = 1'b0; pixel_d = 8'h00; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overlay_pixel <= 8'h00;
            overlay_en    <= 1'b0;
        end else begin
            overlay_pixel <= pixel_d;
            overlay_en    <= en_d;
        end
    end

endmodule

// File: tb/tb_overlay_controller.sv
// ----------------------------------------------------------------------------
// tb_overlay_controller
//   Directed bench for overlay_controller with default parameters
//   (NUM_ICONS=2, 16x16 icons at x=600/624, y=440; READY box 64x8 at
//   272,260; COUNT_SEC=4). The ROMs are modelled as data registers that
//   present a bench-chosen value one cycle after the address register,
//   i.e. in time for the stage-2 register. Honours OVERLAY_BLINK_EN.
// ----------------------------------------------------------------------------
module tb_overlay_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] h_counter;
    logic [9:0]  v_counter;
    logic        one_hz_enable;
    logic        pause;
    logic        pacman_dead;
    logic [1:0]  bonus_eaten;
    logic [7:0]  overlay_pixel;
    logic        overlay_en;
    logic        stall;
    logic [3:0]  countdown;

    logic [1:0]  icon_rom_val;
    logic        ready_rom_val;

    int n_checks = 0;
    int n_pass   = 0;

    overlay_controller_if #(.ICON_ADDR_W(10), .READY_ADDR_W(9)) rom_bus ();

    overlay_controller dut (
        .clk           (clk),
        .reset         (reset),
        .h_counter     (h_counter),
        .v_counter     (v_counter),
        .one_hz_enable (one_hz_enable),
        .pause         (pause),
        .pacman_dead   (pacman_dead),
        .bonus_eaten   (bonus_eaten),
        .rom           (rom_bus),
        .overlay_pixel (overlay_pixel),
        .overlay_en    (overlay_en),
        .stall         (stall),
        .countdown     (countdown)
    );

    always #5 clk = ~clk;

    // ROM data lands mid-cycle after the address register updates.
    always @(negedge clk) begin
        rom_bus.icon_rom_data  <= icon_rom_val;
        rom_bus.ready_rom_data <= ready_rom_val;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs and samples sit 2 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic tick();
        one_hz_enable = 1'b1;
        step();
        one_hz_enable = 1'b0;
    endtask

    task automatic set_pos(input int h, input int v);
        h_counter = 11'(h);
        v_counter = 10'(v);
    endtask

    initial begin
        logic exp_ready;

        reset         = 1'b0;
        one_hz_enable = 1'b0;
        pause         = 1'b0;
        pacman_dead   = 1'b0;
        bonus_eaten   = 2'b00;
        icon_rom_val  = 2'b00;
        ready_rom_val = 1'b1;
        set_pos(272, 260);

        // Reset state
        step();
        step();
        check("rst_stall",      32'(stall),                   32'd1);
        check("rst_countdown",  32'(countdown),               32'd4);
        check("rst_pixel",      32'(overlay_pixel),           32'h00);
        check("rst_en",         32'(overlay_en),              32'd0);
        check("rst_icon_addr",  32'(rom_bus.icon_rom_addr),   32'd0);
        check("rst_ready_addr", 32'(rom_bus.ready_rom_addr),  32'd0);

        reset = 1'b1;

        // Four seconds of stall with the counters parked on the READY origin.
        for (int k = 0; k < 4; k++) begin
            step();
            step();
`ifdef OVERLAY_BLINK_EN
            exp_ready = (k % 2 == 0);
`else
            exp_ready = 1'b1;
`endif
            check($sformatf("sec%0d_stall", k),     32'(stall),         32'd1);
            check($sformatf("sec%0d_countdown", k), 32'(countdown),     32'(4 - k));
            check($sformatf("sec%0d_ready_en", k),  32'(overlay_en),    32'(exp_ready));
            check($sformatf("sec%0d_ready_px", k),  32'(overlay_pixel), exp_ready ? 32'hFC : 32'h00);
            tick();
        end
        check("run_stall",     32'(stall),     32'd0);
        check("run_countdown", 32'(countdown), 32'd0);
        step();
        step();
        check("run_ready_hidden", 32'(overlay_en), 32'd0);
        tick();
        check("tick5_stall",     32'(stall),     32'd0);
        check("tick5_countdown", 32'(countdown), 32'd0);

        // Icon slot 0 origin, eaten, ROM colour 11
        bonus_eaten  = 2'b01;
        icon_rom_val = 2'b11;
        set_pos(600, 440);
        step();
        check("s0_addr", 32'(rom_bus.icon_rom_addr), 32'h100);
        step();
        check("s0_pixel", 32'(overlay_pixel), 32'hFF);
        check("s0_en",    32'(overlay_en),    32'd1);

        // Slot 1 interior (col 5, row 3), pending, ROM colour 01
        icon_rom_val = 2'b01;
        set_pos(629, 443);
        step();
        check("s1_addr", 32'(rom_bus.icon_rom_addr), 32'h235);
        step();
        check("s1_pixel_01", 32'(overlay_pixel), 32'hE0);
        check("s1_en_01",    32'(overlay_en),    32'd1);

        icon_rom_val = 2'b10;
        step();
        step();
        check("s1_pixel_10", 32'(overlay_pixel), 32'h20);

        icon_rom_val = 2'b00;
        step();
        step();
        check("s1_transp_en",    32'(overlay_en),    32'd0);
        check("s1_transp_pixel", 32'(overlay_pixel), 32'h00);

        // Slot 0 bottom-right corner pixel
        icon_rom_val = 2'b11;
        set_pos(615, 455);
        step();
        check("s0_corner_addr", 32'(rom_bus.icon_rom_addr), 32'h1FF);
        step();
        check("s0_corner_pixel", 32'(overlay_pixel), 32'hFF);

        // One past the right edge of slot 1
        set_pos(640, 440);
        step();
        check("past_s1_addr", 32'(rom_bus.icon_rom_addr), 32'd0);
        step();
        check("past_s1_en", 32'(overlay_en), 32'd0);

        // One past the bottom edge of slot 0
        set_pos(600, 456);
        step();
        step();
        check("below_s0_en", 32'(overlay_en), 32'd0);

        // READY box while running
        set_pos(272, 260);
        step();
        step();
        check("ready_run_en", 32'(overlay_en), 32'd0);

        // Death and tick in the same cycle while running
        pacman_dead   = 1'b1;
        one_hz_enable = 1'b1;
        step();
        pacman_dead   = 1'b0;
        one_hz_enable = 1'b0;
        check("dead_stall",     32'(stall),     32'd1);
        check("dead_countdown", 32'(countdown), 32'd4);

        // READY in a fresh stall: mask 0 gives opaque black, mask 1 yellow
        ready_rom_val = 1'b0;
        set_pos(282, 262);
        step();
        check("ready_addr", 32'(rom_bus.ready_rom_addr), 32'h08A);
        step();
        check("ready_d0_en",    32'(overlay_en),    32'd1);
        check("ready_d0_pixel", 32'(overlay_pixel), 32'h00);
        ready_rom_val = 1'b1;
        step();
        step();
        check("ready_d1_pixel", 32'(overlay_pixel), 32'hFC);

        // Icons hidden while stalled
        set_pos(600, 440);
        step();
        step();
        check("icon_stall_en", 32'(overlay_en), 32'd0);

        // Pause freezes the countdown
        tick();
        check("pre_pause_countdown", 32'(countdown), 32'd3);
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            step();
        end
        check("pause_countdown", 32'(countdown), 32'd3);
        check("pause_stall",     32'(stall),     32'd1);
        pause = 1'b0;

        // Bring count to its last value, then death beats expiry
        tick();
        tick();
        check("last_sec_countdown", 32'(countdown), 32'd1);
        pacman_dead   = 1'b1;
        one_hz_enable = 1'b1;
        step();
        pacman_dead   = 1'b0;
        one_hz_enable = 1'b0;
        check("dead_beats_expiry_stall",     32'(stall),     32'd1);
        check("dead_beats_expiry_countdown", 32'(countdown), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
